// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter and the RF write/read-check ports.
// The slave side is the arbiter; the master side represents the core driving requests.
interface rf_wb_arbiter_if;
    logic        p0_valid;
    logic        p0_ready;
    logic [4:0]  p0_waddr;
    logic [31:0] p0_wdata;
    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_waddr;
    logic [31:0] p1_wdata;
    logic        rd_wen;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic [4:0]  rs1_raddr;
    logic [4:0]  rs2_raddr;
    logic        rs1_hazard;
    logic        rs2_hazard;

    modport slave (
        input  p0_valid, p0_waddr, p0_wdata,
        input  p1_valid, p1_waddr, p1_wdata,
        input  rs1_raddr, rs2_raddr,
        output p0_ready, p1_ready,
        output rd_wen, rd_waddr, rd_wdata,
        output rs1_hazard, rs2_hazard
    );

    modport master (
        output p0_valid, p0_waddr, p0_wdata,
        output p1_valid, p1_waddr, p1_wdata,
        output rs1_raddr, rs2_raddr,
        input  p0_ready, p1_ready,
        input  rd_wen, rd_waddr, rd_wdata,
        input  rs1_hazard, rs2_hazard
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source writeback arbiter for the RF write port: fixed priority to port 0 with a
// starvation counter guaranteeing port 1 progress, a registered write stage and RAW hazard flags.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic        grant_p0;
    logic        grant_p1;
    logic        hs;
    logic [4:0]  win_waddr;
    logic [31:0] win_wdata;

    // Port 1 wins when starved or when port 0 is idle.
    always_comb begin
        grant_p1  = bus.p1_valid && ((starve_cnt == LIMIT) || !bus.p0_valid);
        grant_p0  = bus.p0_valid && !grant_p1;
        hs        = grant_p0 || grant_p1;
        win_waddr = grant_p1 ? bus.p1_waddr : bus.p0_waddr;
        win_wdata = grant_p1 ? bus.p1_wdata : bus.p0_wdata;
    end

    assign bus.p0_ready = grant_p0;
    assign bus.p1_ready = grant_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.p1_valid || grant_p1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // x0 writes complete the handshake but never enable the RF.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.rd_wen   <= 1'b0;
            bus.rd_waddr <= '0;
            bus.rd_wdata <= '0;
        end else begin
            bus.rd_wen <= hs && (win_waddr != 5'd0);
            if (hs) begin
                bus.rd_waddr <= win_waddr;
                bus.rd_wdata <= win_wdata;
            end
        end
    end

    function automatic logic hazard(input logic [4:0] rs);
        return (rs != 5'd0) &&
               ((bus.rd_wen   && (bus.rd_waddr == rs)) ||
                (bus.p0_valid && (bus.p0_waddr == rs)) ||
                (bus.p1_valid && (bus.p1_waddr == rs)));
    endfunction

    assign bus.rs1_hazard = hazard(bus.rs1_raddr);
    assign bus.rs2_hazard = hazard(bus.rs2_raddr);
endmodule
